instr_encode_loader: RTL and testbench

Program loader for the single-cycle RISC-V core. It accepts decoded instruction fields over a valid/ready stream and encodes them into RV32I words for the six classes the main controller decodes: LW, SW, R-type, B-type, I-type and LUI. It writes the words into instruction memory at consecutive word addresses. It is the encoder counterpart of the opcode decoder, and the bench and boot path use it to fill instruction memory before the core leaves reset.

---
 rtl/instr_encode_pkg.sv | 31 +++
 rtl/rv_instr_encode.sv | 33 +++
 rtl/instr_encode_loader.sv | 105 ++++++++++
 tb/tb_instr_encode_loader.sv | 317 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_encode_pkg.sv
// Shared constants for the RV32I program loader: class codes, opcodes, loader states.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package instr_encode_pkg;

    localparam logic [2:0] CLS_LW  = 3'd0;
    localparam logic [2:0] CLS_SW  = 3'd1;
    localparam logic [2:0] CLS_RT  = 3'd2;
    localparam logic [2:0] CLS_BT  = 3'd3;
    localparam logic [2:0] CLS_IT  = 3'd4;
    localparam logic [2:0] CLS_LUI = 3'd5;

    // Same 7-bit opcode values the core's main controller decodes.
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_RT  = 7'b0110011;
    localparam logic [6:0] OP_BT  = 7'b1100011;
    localparam logic [6:0] OP_IT  = 7'b0010011;
    localparam logic [6:0] OP_LUI = 7'b0110111;

    localparam logic [2:0] F3_WORD = 3'b010;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_FLUSH,
        ST_DONE,
        ST_ERR
    } state_t;

endpackage

// File: rtl/rv_instr_encode.sv
// Field-to-word RV32I encoder for the six loader classes; flags classes 6/7 as illegal.
// Latency: combinational.
// Backpressure: none; the loader registers the word.
module rv_instr_encode
    import instr_encode_pkg::*;
(
    input  logic [2:0]  cls,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic        funct7b5,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        case (cls)
            CLS_LW:  word = {imm[11:0], rs1, F3_WORD, rd, OP_LW};
            CLS_SW:  word = {imm[11:5], rs2, rs1, F3_WORD, imm[4:0], OP_SW};
            CLS_RT:  word = {1'b0, funct7b5, 5'b00000, rs2, rs1, funct3, rd, OP_RT};
            // Branch offsets are halfword-aligned, so imm[0] has no slot.
            CLS_BT:  word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OP_BT};
            CLS_IT:  word = {imm[11:0], rs1, funct3, rd, OP_IT};
            CLS_LUI: word = {imm[31:12], rd, OP_LUI};
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encode_loader.sv
// Streams decoded instruction fields in, writes encoded RV32I words to consecutive imem addresses.
// Latency: accepted beat -> mem_we one cycle later; last beat -> done two cycles later.
// Backpressure: in_ready only in LOAD without start; an illegal beat or address overflow parks in ERR.
module instr_encode_loader
    import instr_encode_pkg::*;
#(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_class,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rs1,
    input  logic [4:0]        in_rs2,
    input  logic [2:0]        in_funct3,
    input  logic              in_funct7b5,
    input  logic [31:0]       in_imm,
    input  logic              in_last,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   count
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

    state_t            state;
    logic [ADDR_W-1:0] addr;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic              accept;

    rv_instr_encode u_enc (
        .cls      (in_class),
        .rd       (in_rd),
        .rs1      (in_rs1),
        .rs2      (in_rs2),
        .funct3   (in_funct3),
        .funct7b5 (in_funct7b5),
        .imm      (in_imm),
        .word     (enc_word),
        .illegal  (enc_illegal)
    );

    assign in_ready = (state == ST_LOAD) && !start;
    assign accept   = in_valid && in_ready;
    assign busy     = (state == ST_LOAD) || (state == ST_FLUSH) || (state == ST_DONE);
    assign done     = (state == ST_DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            addr      <= '0;
            count     <= '0;
            err       <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
        end else begin
            mem_we <= 1'b0;
            // start wins from any state; a write already registered still reaches memory this cycle.
            if (start) begin
                state <= ST_LOAD;
                addr  <= '0;
                count <= '0;
                err   <= 1'b0;
            end else begin
                case (state)
                    ST_LOAD: begin
                        if (accept) begin
                            if (enc_illegal) begin
                                err   <= 1'b1;
                                state <= ST_ERR;
                            end else begin
                                mem_we    <= 1'b1;
                                mem_addr  <= addr;
                                mem_wdata <= enc_word;
                                count     <= count + (ADDR_W+1)'(1);
                                if (in_last) begin
                                    state <= ST_FLUSH;
                                end else if (addr == ADDR_MAX) begin
                                    // Memory full with more to come: stop rather than wrap onto word 0.
                                    err   <= 1'b1;
                                    state <= ST_ERR;
                                end else begin
                                    addr <= addr + ADDR_W'(1);
                                end
                            end
                        end
                    end
                    ST_FLUSH: state <= ST_DONE;
                    ST_DONE:  state <= ST_IDLE;
                    default:  state <= state;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_instr_encode_loader.sv
// Bench for instr_encode_loader: encoder table, timing sequences, error/overflow/reset corners, random sessions.
module tb_instr_encode_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, start_s;
    logic        in_valid, in_valid_s;
    logic [2:0]  in_class;
    logic [4:0]  in_rd, in_rs1, in_rs2;
    logic [2:0]  in_funct3;
    logic        in_funct7b5;
    logic [31:0] in_imm;
    logic        in_last;

    logic        in_ready, mem_we, busy, done, err;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic [8:0]  count;

    logic        in_ready_s, mem_we_s, busy_s, done_s, err_s;
    logic [1:0]  mem_addr_s;
    logic [31:0] mem_wdata_s;
    logic [2:0]  count_s;

    always #5 clk = ~clk;

    instr_encode_loader #(.ADDR_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .in_valid(in_valid), .in_ready(in_ready),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .done(done), .err(err), .count(count)
    );

    instr_encode_loader #(.ADDR_W(2)) dut_s (
        .clk(clk), .rst(rst), .start(start_s), .in_valid(in_valid_s), .in_ready(in_ready_s),
        .in_class(in_class), .in_rd(in_rd), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_funct3(in_funct3), .in_funct7b5(in_funct7b5), .in_imm(in_imm), .in_last(in_last),
        .mem_we(mem_we_s), .mem_addr(mem_addr_s), .mem_wdata(mem_wdata_s),
        .busy(busy_s), .done(done_s), .err(err_s), .count(count_s)
    );

    int n_vec = 0;
    int n_bad = 0;

    logic [39:0] wq[$];
    int          done_cnt = 0;

    always @(negedge clk) begin
        if (mem_we) wq.push_back({mem_addr, mem_wdata});
        if (done) done_cnt++;
    end

    typedef struct {
        logic [2:0]  cls;
        logic [4:0]  rd, rs1, rs2;
        logic [2:0]  f3;
        logic        f7;
        logic [31:0] imm;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl[7];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Plain shift-and-or encoding straight from the RV32I field layouts.
    function automatic logic [31:0] ref_enc(input int c, input logic [31:0] rd, rs1, rs2, f3, f7, imm);
        case (c)
            0: ref_enc = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (32'd2 << 12) | (rd << 7) | 32'h03;
            1: ref_enc = (((imm >> 5) & 32'h7F) << 25) | (rs2 << 20) | (rs1 << 15) | (32'd2 << 12)
                         | ((imm & 32'h1F) << 7) | 32'h23;
            2: ref_enc = (f7 << 30) | (rs2 << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h33;
            3: ref_enc = (((imm >> 12) & 32'h1) << 31) | (((imm >> 5) & 32'h3F) << 25) | (rs2 << 20)
                         | (rs1 << 15) | (f3 << 12) | (((imm >> 1) & 32'hF) << 8)
                         | (((imm >> 11) & 32'h1) << 7) | 32'h63;
            4: ref_enc = ((imm & 32'hFFF) << 20) | (rs1 << 15) | (f3 << 12) | (rd << 7) | 32'h13;
            5: ref_enc = (imm & 32'hFFFFF000) | (rd << 7) | 32'h37;
            default: ref_enc = 32'h0;
        endcase
    endfunction

    task automatic drive_beat(input logic [2:0] c, input logic [4:0] rd, rs1, rs2,
                              input logic [2:0] f3, input logic f7, input logic [31:0] imm,
                              input logic last);
        in_class = c; in_rd = rd; in_rs1 = rs1; in_rs2 = rs2;
        in_funct3 = f3; in_funct7b5 = f7; in_imm = imm; in_last = last;
        in_valid = 1'b1;
    endtask

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1 start = 1'b0;
    endtask

    // Returns #1 after the edge that accepted the beat.
    task automatic wait_accept();
        bit ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (in_ready) ok = 1'b1;
        end
        if (ok) begin
            @(posedge clk); #1;
        end
        chk("accept", {63'd0, ok}, 64'd1);
    endtask

    initial begin
        logic [1:0] wa[4];
        int         acc, nw, dseen, base, dbase, nb;
        bit         err_exp;
        logic [39:0] eq[$];
        logic [2:0]  rc;
        logic [4:0]  rrd, rrs1, rrs2;
        logic [2:0]  rf3;
        logic        rf7;
        logic [31:0] rimm;

        tbl[0] = '{3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0,          32'h002081B3};
        tbl[1] = '{3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b1, 32'd0,          32'h402081B3};
        tbl[2] = '{3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd8,          32'h00812283};
        tbl[3] = '{3'd1, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 32'd12,         32'h00512623};
        tbl[4] = '{3'd5, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000,   32'h123453B7};
        tbl[5] = '{3'd3, 5'd0, 5'd1, 5'd2, 3'd0, 1'b0, 32'hFFFFFFF8,   32'hFE208CE3};
        tbl[6] = '{3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5,          32'h00500093};

        rst = 1'b1; start = 1'b0; start_s = 1'b0; in_valid = 1'b0; in_valid_s = 1'b0;
        in_class = '0; in_rd = '0; in_rs1 = '0; in_rs2 = '0; in_funct3 = '0;
        in_funct7b5 = 1'b0; in_imm = '0; in_last = 1'b0;

        #3;
        chk("rst_in_ready", {63'd0, in_ready}, 64'd0);
        chk("rst_mem_we", {63'd0, mem_we}, 64'd0);
        chk("rst_mem_addr", {56'd0, mem_addr}, 64'd0);
        chk("rst_mem_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("rst_busy", {63'd0, busy}, 64'd0);
        chk("rst_done", {63'd0, done}, 64'd0);
        chk("rst_err", {63'd0, err}, 64'd0);
        chk("rst_count", {55'd0, count}, 64'd0);
        chk("rst_s_count", {61'd0, count_s}, 64'd0);
        #9 rst = 1'b0;

        // Single-beat sessions: encoding, write latency, done timing.
        for (int i = 0; i < 7; i++) begin
            pulse_start();
            drive_beat(tbl[i].cls, tbl[i].rd, tbl[i].rs1, tbl[i].rs2, tbl[i].f3, tbl[i].f7, tbl[i].imm, 1'b1);
            wait_accept();
            in_valid = 1'b0;
            @(negedge clk);
            chk($sformatf("tbl%0d_we", i), {63'd0, mem_we}, 64'd1);
            chk($sformatf("tbl%0d_addr", i), {56'd0, mem_addr}, 64'd0);
            chk($sformatf("tbl%0d_wdata", i), {32'd0, mem_wdata}, {32'd0, tbl[i].exp});
            chk($sformatf("tbl%0d_count", i), {55'd0, count}, 64'd1);
            chk($sformatf("tbl%0d_done_early", i), {63'd0, done}, 64'd0);
            @(negedge clk);
            chk($sformatf("tbl%0d_done", i), {63'd0, done}, 64'd1);
            chk($sformatf("tbl%0d_we_off", i), {63'd0, mem_we}, 64'd0);
            chk($sformatf("tbl%0d_busy_done", i), {63'd0, busy}, 64'd1);
            @(negedge clk);
            chk($sformatf("tbl%0d_idle_busy", i), {63'd0, busy}, 64'd0);
            chk($sformatf("tbl%0d_idle_done", i), {63'd0, done}, 64'd0);
        end

        // Back-to-back beats, one per cycle.
        pulse_start();
        drive_beat(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd8, 1'b0);
        wait_accept();
        drive_beat(3'd1, 5'd0, 5'd2, 5'd5, 3'd0, 1'b0, 32'd12, 1'b0);
        @(negedge clk);
        chk("b2b_we0", {63'd0, mem_we}, 64'd1);
        chk("b2b_w0", {24'd0, mem_addr, mem_wdata}, {24'd0, 8'd0, 32'h00812283});
        chk("b2b_ready", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1;
        drive_beat(3'd5, 5'd7, 5'd0, 5'd0, 3'd0, 1'b0, 32'h12345000, 1'b1);
        @(negedge clk);
        chk("b2b_we1", {63'd0, mem_we}, 64'd1);
        chk("b2b_w1", {24'd0, mem_addr, mem_wdata}, {24'd0, 8'd1, 32'h00512623});
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("b2b_we2", {63'd0, mem_we}, 64'd1);
        chk("b2b_w2", {24'd0, mem_addr, mem_wdata}, {24'd0, 8'd2, 32'h123453B7});
        chk("b2b_count", {55'd0, count}, 64'd3);
        @(negedge clk);
        chk("b2b_done", {63'd0, done}, 64'd1);
        chk("b2b_we_off", {63'd0, mem_we}, 64'd0);

        // Illegal class after one legal beat, then recovery via start.
        pulse_start();
        drive_beat(3'd4, 5'd1, 5'd0, 5'd0, 3'd0, 1'b0, 32'd5, 1'b0);
        wait_accept();
        drive_beat(3'd6, 5'd9, 5'd9, 5'd9, 3'd0, 1'b0, 32'd0, 1'b0);
        @(negedge clk);
        chk("ill_first_we", {63'd0, mem_we}, 64'd1);
        chk("ill_ready_before", {63'd0, in_ready}, 64'd1);
        @(posedge clk); #1 in_valid = 1'b0;
        @(negedge clk);
        chk("ill_err", {63'd0, err}, 64'd1);
        chk("ill_ready", {63'd0, in_ready}, 64'd0);
        chk("ill_no_write", {63'd0, mem_we}, 64'd0);
        chk("ill_count", {55'd0, count}, 64'd1);
        dseen = 0;
        repeat (4) begin
            @(negedge clk);
            if (done) dseen++;
        end
        chk("ill_no_done", dseen, 0);
        chk("ill_err_sticky", {63'd0, err}, 64'd1);
        pulse_start();
        @(negedge clk);
        chk("ill_restart_err", {63'd0, err}, 64'd0);
        chk("ill_restart_count", {55'd0, count}, 64'd0);
        @(posedge clk); #1;
        drive_beat(3'd2, 5'd3, 5'd1, 5'd2, 3'd0, 1'b0, 32'd0, 1'b1);
        wait_accept();
        in_valid = 1'b0;
        @(negedge clk);
        chk("ill_rewrite", {24'd0, mem_addr, mem_wdata}, {24'd0, 8'd0, 32'h002081B3});
        repeat (3) @(negedge clk);

        // Overflow on the 4-word instance: five beats offered, no in_last.
        @(posedge clk); #1 start_s = 1'b1;
        @(posedge clk); #1 start_s = 1'b0;
        in_class = 3'd4; in_rd = 5'd2; in_rs1 = 5'd0; in_funct3 = 3'd0; in_imm = 32'd1; in_last = 1'b0;
        in_valid_s = 1'b1;
        acc = 0; nw = 0; dseen = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (in_valid_s && in_ready_s) acc++;
            if (mem_we_s) begin
                if (nw < 4) wa[nw] = mem_addr_s;
                nw++;
                if (mem_addr_s == 2'd3) chk("ovf_err_at_4th", {63'd0, err_s}, 64'd1);
            end
            if (done_s) dseen++;
            if (acc == 5) in_valid_s = 1'b0;
            @(posedge clk); #1;
        end
        in_valid_s = 1'b0;
        chk("ovf_accepted", acc, 4);
        chk("ovf_writes", nw, 4);
        for (int k = 0; k < 4; k++) chk($sformatf("ovf_addr%0d", k), {62'd0, wa[k]}, k);
        chk("ovf_err", {63'd0, err_s}, 64'd1);
        chk("ovf_count", {61'd0, count_s}, 64'd4);
        chk("ovf_no_done", dseen, 0);
        chk("ovf_busy", {63'd0, busy_s}, 64'd0);

        // Asynchronous reset right after an accepted beat.
        pulse_start();
        drive_beat(3'd0, 5'd5, 5'd2, 5'd0, 3'd0, 1'b0, 32'd8, 1'b0);
        wait_accept();
        in_valid = 1'b0;
        chk("arst_pre_we", {63'd0, mem_we}, 64'd1);
        #1 rst = 1'b1;
        #1;
        chk("arst_we", {63'd0, mem_we}, 64'd0);
        chk("arst_ready", {63'd0, in_ready}, 64'd0);
        chk("arst_busy", {63'd0, busy}, 64'd0);
        chk("arst_count", {55'd0, count}, 64'd0);
        chk("arst_addr", {56'd0, mem_addr}, 64'd0);
        chk("arst_wdata", {32'd0, mem_wdata}, 64'd0);
        chk("arst_err", {63'd0, err}, 64'd0);
        chk("arst_done", {63'd0, done}, 64'd0);
        @(posedge clk); #1 rst = 1'b0;

        // Random sessions against the reference model.
        for (int s = 0; s < 40; s++) begin
            pulse_start();
            base = wq.size(); dbase = done_cnt; eq.delete(); err_exp = 1'b0;
            nb = $urandom_range(1, 6);
            for (int b = 0; b < nb; b++) begin
                in_valid = 1'b0;
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk); #1;
                end
                rc   = ($urandom_range(0, 9) == 0) ? 3'($urandom_range(6, 7)) : 3'($urandom_range(0, 5));
                rrd  = 5'($urandom_range(0, 31));
                rrs1 = 5'($urandom_range(0, 31));
                rrs2 = 5'($urandom_range(0, 31));
                rf3  = 3'($urandom_range(0, 7));
                rf7  = 1'($urandom_range(0, 1));
                rimm = $urandom;
                drive_beat(rc, rrd, rrs1, rrs2, rf3, rf7, rimm, (b == nb - 1) ? 1'b1 : 1'b0);
                wait_accept();
                in_valid = 1'b0;
                if (rc > 3'd5) begin
                    err_exp = 1'b1;
                    break;
                end
                eq.push_back({8'(b), ref_enc(int'(rc), 32'(rrd), 32'(rrs1), 32'(rrs2), 32'(rf3), 32'(rf7), rimm)});
            end
            repeat (4) @(negedge clk);
            chk($sformatf("rnd%0d_nwrites", s), wq.size() - base, eq.size());
            for (int i = 0; i < eq.size() && base + i < wq.size(); i++)
                chk($sformatf("rnd%0d_w%0d", s, i), {24'd0, wq[base + i]}, {24'd0, eq[i]});
            chk($sformatf("rnd%0d_err", s), {63'd0, err}, {63'd0, err_exp});
            chk($sformatf("rnd%0d_done", s), done_cnt - dbase, err_exp ? 0 : 1);
            chk($sformatf("rnd%0d_busy", s), {63'd0, busy}, 64'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
